// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the 2x2 multi-channel pooling stage.
// Average datapath is built only when POOL_AVG_EN is defined.
package cnn_pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  localparam int MW = 64;

  function automatic int clog1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [MW-1:0] smax(
    input logic signed [MW-1:0] a,
    input logic signed [MW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_pool_2x2_multich_if.sv
// Raster stream in, pooled stream out, with squeeze back-pressure.
// Master drives pixels; slave is the pooling stage.
interface cnn_pool_2x2_multich_if #(
  parameter int DW = 24,
  parameter int CH = 4
);
  logic          DIN_VALID;
  logic [CH*DW-1:0] DIN;
  logic          MODE;
  logic          SQUEEZE;
  logic          SQUEEZE_OUT;
  logic [CH*DW-1:0] OUT;
  logic          VALID;
  logic          LAST_IN_LINE;
  logic          LAST_PIX;

  modport master (
    output DIN_VALID, DIN, MODE, SQUEEZE,
    input  SQUEEZE_OUT, OUT, VALID,
    input  LAST_IN_LINE, LAST_PIX
  );

  modport slave (
    input  DIN_VALID, DIN, MODE, SQUEEZE,
    output SQUEEZE_OUT, OUT, VALID,
    output LAST_IN_LINE, LAST_PIX
  );
endinterface

// File: rtl/cnn_pool_lane.sv
// One channel: hold reg, pair combine, line buffer, final combine.
// Line buffer is DW+1 wide only when POOL_AVG_EN is defined.
module cnn_pool_lane
  import cnn_pool_pkg::*;
#(
  parameter int DW = 24,
  parameter int NB = 32,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc,
  input  logic                 odd_col,
  input  logic                 odd_row,
  input  logic [AW-1:0]        idx,
`ifdef POOL_AVG_EN
  input  logic                 avg,
`endif
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] q
);
`ifdef POOL_AVG_EN
  localparam int LW = DW + 1;
`else
  localparam int LW = DW;
`endif

  logic signed [DW-1:0] hold_q;
  logic signed [LW-1:0] lb [NB];
  logic signed [LW-1:0] pair;
  logic signed [LW-1:0] prev;
  logic signed [DW-1:0] fin;
  logic signed [MW-1:0] pmax;
  logic signed [MW-1:0] fmax;
  logic                 unused_hi;

  assign prev = lb[idx];
  assign pmax = smax(MW'(hold_q), MW'(din));
  assign fmax = smax(MW'(pair), MW'(prev));
  assign unused_hi = ^{pmax[MW-1:LW], fmax[MW-1:DW]};

`ifdef POOL_AVG_EN
  logic signed [DW+1:0] sum4;
  assign sum4 = (DW+2)'(pair) + (DW+2)'(prev);
`endif

  // Pair and final combine; average floors via arithmetic shift
  always_comb begin
    pair = pmax[LW-1:0];
    fin  = fmax[DW-1:0];
`ifdef POOL_AVG_EN
    if (avg) begin
      pair = LW'(hold_q) + LW'(din);
      fin  = DW'(sum4 >>> 2);
    end
`endif
  end

  // Hold the even-column pixel and register finished outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      q      <= '0;
    end else if (acc) begin
      if (!odd_col) hold_q <= din;
      if (odd_col && odd_row) q <= fin;
    end
  end

  // Even rows park pair values; never cleared, always rewritten first
  always_ff @(posedge clk) begin
    if (acc && odd_col && !odd_row) lb[idx] <= pair;
  end

endmodule

// File: rtl/cnn_pool_2x2_multich.sv
// 2x2 stride-2 max/average pooling over CH lockstep channels.
// POOL_AVG_EN enables the run-time average mode.
module cnn_pool_2x2_multich
  import cnn_pool_pkg::*;
#(
  parameter int DW       = 24,
  parameter int CH       = 4,
  parameter int P_WIDTH  = 64,
  parameter int P_HEIGHT = 64
) (
  input logic CLK,
  input logic RST,
  cnn_pool_2x2_multich_if.slave bus
);
  localparam int CW = clog1(P_WIDTH);
  localparam int RW = clog1(P_HEIGHT);
  localparam int NB = P_WIDTH / 2;
  localparam int AW = clog1(NB);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] idx;
  logic          acc;
  logic          eol;
  logic          eof;
  logic          produce;

  assign acc     = bus.DIN_VALID && !bus.SQUEEZE;
  assign eol     = col_q == CW'(P_WIDTH - 1);
  assign eof     = row_q == RW'(P_HEIGHT - 1);
  assign produce = acc && col_q[0] && row_q[0];
  assign idx     = AW'(col_q >> 1);
  assign bus.SQUEEZE_OUT = bus.SQUEEZE;

  // Raster position of the next accepted pixel
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_q <= '0;
      row_q <= '0;
    end else if (acc) begin
      if (eol) begin
        col_q <= '0;
        row_q <= eof ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

`ifdef POOL_AVG_EN
  pool_mode_t mode_q;
  logic       avg;
  assign avg = mode_q == POOL_AVG;

  // Mode is sampled only on the first pixel of a frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= POOL_MAX;
    end else if (acc && col_q == '0 && row_q == '0) begin
      mode_q <= pool_mode_t'(bus.MODE);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.MODE;
`endif

  // Output strobes travel with OUT and freeze under squeeze
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.VALID        <= 1'b0;
      bus.LAST_IN_LINE <= 1'b0;
      bus.LAST_PIX     <= 1'b0;
    end else if (acc) begin
      bus.VALID        <= produce;
      bus.LAST_IN_LINE <= produce && eol;
      bus.LAST_PIX     <= produce && eol && eof;
    end else if (!bus.SQUEEZE) begin
      bus.VALID        <= 1'b0;
      bus.LAST_IN_LINE <= 1'b0;
      bus.LAST_PIX     <= 1'b0;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic signed [DW-1:0] q;

    cnn_pool_lane #(
      .DW(DW),
      .NB(NB),
      .AW(AW)
    ) u_lane (
      .clk    (CLK),
      .rst    (RST),
      .acc    (acc),
      .odd_col(col_q[0]),
      .odd_row(row_q[0]),
      .idx    (idx),
`ifdef POOL_AVG_EN
      .avg    (avg),
`endif
      .din    (bus.DIN[c*DW +: DW]),
      .q      (q)
    );

    assign bus.OUT[c*DW +: DW] = q;
  end

endmodule

// File: tb/tb_cnn_pool_2x2_multich.sv
// Directed bench for cnn_pool_2x2_multich on a 4x4, 2-channel frame.
// Average expectations apply only when POOL_AVG_EN is defined.
module tb_cnn_pool_2x2_multich;
  localparam int DW = 24;
  localparam int CH = 2;
  localparam int PW = 4;
  localparam int PH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_pool_2x2_multich_if #(.DW(DW), .CH(CH)) bus ();

  cnn_pool_2x2_multich #(
    .DW(DW), .CH(CH), .P_WIDTH(PW), .P_HEIGHT(PH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic signed [DW-1:0] d0;
    logic signed [DW-1:0] d1;
    logic lil;
    logic lp;
  } out_t;

  typedef struct {
    string name;
    logic  mode;
    int    scale;
    int    off;
    int    gap;
    int    e0[4];
    int    e1[4];
  } vec_t;

  out_t got_q[$];
  out_t exp_q[$];
  vec_t vecs[4];
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin : mon
    out_t o;
    if (bus.VALID && !bus.SQUEEZE) begin
      o.d0  = bus.OUT[0 +: DW];
      o.d1  = bus.OUT[DW +: DW];
      o.lil = bus.LAST_IN_LINE;
      o.lp  = bus.LAST_PIX;
      got_q.push_back(o);
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic set_pix(input int v, input logic m);
    bus.DIN_VALID = 1'b1;
    bus.DIN[0 +: DW] = DW'(v);
    bus.DIN[DW +: DW] = DW'(-v);
    bus.MODE = m;
  endtask

  task automatic drive_pix(input int v, input logic m);
    set_pix(v, m);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.DIN_VALID = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input vec_t v, input int flip_at,
                             input int stall_at);
    logic m;
    int   p;
    for (int i = 0; i < PW*PH; i++) begin
      m = (flip_at >= 0 && i >= flip_at) ? ~v.mode : v.mode;
      p = v.scale * i + v.off;
      if (i == stall_at) begin
        set_pix(p, m);
        bus.SQUEEZE = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_valid", bus.VALID, 1);
          chk("stall_out0", $signed(bus.OUT[0 +: DW]), v.e0[1]);
          chk("stall_sqo", bus.SQUEEZE_OUT, 1);
          @(posedge clk); #1;
        end
        bus.SQUEEZE = 1'b0;
      end
      drive_pix(p, m);
      if (v.gap > 0 && (i % v.gap) == 0) idle();
    end
  endtask

  task automatic push_exp(input vec_t v);
    out_t o;
    for (int k = 0; k < 4; k++) begin
      o.d0  = DW'(v.e0[k]);
      o.d1  = DW'(v.e1[k]);
      o.lil = (k % 2) == 1;
      o.lp  = k == 3;
      exp_q.push_back(o);
    end
  endtask

  task automatic compare(input string nm);
    int n;
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_ch0_%0d", nm, k), got_q[k].d0, exp_q[k].d0);
      chk($sformatf("%s_ch1_%0d", nm, k), got_q[k].d1, exp_q[k].d1);
      chk($sformatf("%s_lil_%0d", nm, k), got_q[k].lil, exp_q[k].lil);
      chk($sformatf("%s_lp_%0d", nm, k), got_q[k].lp, exp_q[k].lp);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{"max_idx", 1'b0, 1, 0, 0,
                '{5, 7, 13, 15}, '{0, -2, -8, -10}};
    vecs[2] = '{"max_s3", 1'b0, 3, -20, 3,
                '{-5, 1, 19, 25}, '{20, 14, -4, -10}};
`ifdef POOL_AVG_EN
    vecs[1] = '{"avg_idx", 1'b1, 1, 0, 0,
                '{2, 4, 10, 12}, '{-3, -5, -11, -13}};
    vecs[3] = '{"avg_s3", 1'b1, 3, -20, 0,
                '{-13, -7, 11, 17}, '{12, 6, -12, -18}};
`else
    vecs[1] = '{"avg_idx", 1'b1, 1, 0, 0,
                '{5, 7, 13, 15}, '{0, -2, -8, -10}};
    vecs[3] = '{"avg_s3", 1'b1, 3, -20, 0,
                '{-5, 1, 19, 25}, '{20, 14, -4, -10}};
`endif

    bus.DIN_VALID = 1'b0;
    bus.DIN = '0;
    bus.MODE = 1'b0;
    bus.SQUEEZE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_out", bus.OUT, 0);
    chk("rst_lil", bus.LAST_IN_LINE, 0);
    chk("rst_lp", bus.LAST_PIX, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      push_exp(vecs[i]);
      drive_frame(vecs[i], -1, -1);
      idle();
      idle();
      compare(vecs[i].name);
    end

    push_exp(vecs[0]);
    drive_frame(vecs[0], -1, 8);
    idle();
    idle();
    compare("squeeze");

    push_exp(vecs[0]);
    push_exp(vecs[3]);
    drive_frame(vecs[0], -1, -1);
    drive_frame(vecs[3], -1, -1);
    idle();
    idle();
    compare("b2b");

    for (int i = 0; i < 6; i++) drive_pix(i, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", bus.VALID, 1);
    chk("pre_rst_out0", $signed(bus.OUT[0 +: DW]), 5);
    #1;
    rst = 1'b1;
    bus.DIN_VALID = 1'b0;
    bus.SQUEEZE = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.VALID, 0);
    chk("mid_rst_out", bus.OUT, 0);
    chk("mid_rst_lil", bus.LAST_IN_LINE, 0);
    chk("mid_rst_lp", bus.LAST_PIX, 0);
    chk("mid_rst_sqo", bus.SQUEEZE_OUT, 1);
    #1;
    rst = 1'b0;
    bus.SQUEEZE = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    push_exp(vecs[0]);
    drive_frame(vecs[0], -1, -1);
    idle();
    idle();
    compare("after_rst");

    push_exp(vecs[0]);
    push_exp(vecs[1]);
    drive_frame(vecs[0], 7, -1);
    drive_frame(vecs[1], -1, -1);
    idle();
    idle();
    compare("mode_flip");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_pool_2x2_multich.md
# cnn_pool_2x2_multich

Parametrised 2x2 / stride-2 pooling stage for the CNN feature-map pipeline, processing CH channels in lockstep on one packed raster stream. It generalises the single-channel pooling cores: configurable frame size and channel count, run-time max/average mode, and the same SQUEEZE back-pressure and LAST_IN_LINE/LAST_PIX framing. It sits between a conv core (or another pooling stage) and the next layer.

## Interface
- DW, 24, signed fixed-point sample width (1 sign, 5 integer bits, rest fraction)
- CH, 4, number of channels packed on DIN/OUT
- P_WIDTH, 64, input line width in pixels; even, >= 2
- P_HEIGHT, 64, input frame height in lines; even, >= 2
- CLK  input  1  clock; one clock domain, all logic rising-edge
- RST  input  1  synchronous, active-high reset
- DIN_VALID  input  1  input pixel present
- DIN  input  CH*DW  packed pixels, channel c at [c*DW +: DW]
- MODE  input  1  0 = max, 1 = average; latched at the first pixel of each frame
- SQUEEZE  input  1  downstream stall
- SQUEEZE_OUT  output  1  stall to upstream
- OUT  output  CH*DW  pooled pixels, same packing as DIN
- VALID  output  1  OUT holds a new pooled pixel
- LAST_IN_LINE  output  1  with VALID: last pooled pixel of an output line
- LAST_PIX  output  1  with VALID: last pooled pixel of the frame

## Operation
- Accept condition: DIN_VALID && !SQUEEZE. While SQUEEZE = 1, state is frozen: counters, hold registers, line buffer and output registers. DIN is not consumed, and upstream must hold it.
- SQUEEZE_OUT = SQUEEZE, combinational with no added latency.
- Raster counters col (0..P_WIDTH-1) and row (0..P_HEIGHT-1) advance on each accepted pixel.
  - col wraps to 0 and row increments at end of line.
  - row wraps to 0 at end of frame, so back-to-back frames need no gap.
- Per channel, each accepted pixel is handled as follows:
  - Even col: store pixel in the hold register.
  - Odd col: form the pair value P from the hold register and the pixel. Max mode gives the signed max. Average mode gives the DW+1-bit signed sum.
  - Even row: write P to linebuf[col>>1]. The buffer holds P_WIDTH/2 entries of DW+1 bits per channel.
  - Odd row: combine P with linebuf[col>>1] and register the result into OUT.
- Arithmetic:
  - Max mode: signed compare, exact.
  - Average mode: the DW+2-bit four-sample sum is arithmetic-shifted right by 2 (floor toward -inf), then truncated to DW bits.
  - No rounding and no saturation is needed, because the average always lies within range.
- MODE is latched when col = row = 0 is accepted. Changes mid-frame take effect at the next frame.
- Framing outputs:
  - LAST_IN_LINE = VALID && (col>>1) == P_WIDTH/2-1.
  - LAST_PIX = VALID && that condition && row == P_HEIGHT-1.
  - Both are registered alongside OUT.
- Line buffer contents are never cleared; every entry is rewritten on an even row before it is read.

## Timing
- Latency: VALID rises on the cycle after the accepting edge of an odd-row, odd-col pixel.
- VALID is high for one cycle when SQUEEZE = 0. If SQUEEZE rises, VALID/OUT/LAST_* hold until SQUEEZE falls, and downstream samples only when SQUEEZE = 0.
- Throughput: one input pixel per cycle; one output per 4 inputs on average, bursty on odd rows.
- Reset values: OUT = 0, VALID = 0, LAST_IN_LINE = 0, LAST_PIX = 0, col = row = 0, latched mode = max. SQUEEZE_OUT follows SQUEEZE even during reset.
- Reset mid-frame abandons the partial frame. The next accepted pixel is treated as (0,0).
- DIN_VALID = 0 gaps are allowed anywhere, with no effect on state.

## Configuration
- POOL_AVG_EN defined: MODE input honoured, and the average datapath and DW+1-bit line buffer are built.
- POOL_AVG_EN undefined:
  - MODE is ignored and the block is max-only.
  - The line buffer is DW bits wide.
  - Port list is unchanged.

## Structure
- Package cnn_pool_pkg holds:
  - pool_mode_t enum (POOL_MAX = 0, POOL_AVG = 1)
  - localparam helpers for counter widths ($clog2 of P_WIDTH, P_HEIGHT)
  - a signed-max function
- Sub-module cnn_pool_lane is the per-channel datapath: hold register, pair combine, line buffer, final combine and output register. It is instantiated CH times via generate.
- Counters, mode latch, accept logic and framing flags stay in the top module and are shared by all lanes.

## Test plan
- Max mode, P_WIDTH = P_HEIGHT = 4, CH = 2, ch0 = raster index 0..15, ch1 = -index:
  - ch0 OUT = 5, 7, 13, 15; ch1 OUT = 0, -2, -8, -10.
  - LAST_IN_LINE on outputs 2 and 4; LAST_PIX on output 4.
- Average mode, same stimulus:
  - ch0 OUT = 2, 4, 10, 12 (floor).
  - ch1 first OUT = -3 (floor of -2.5).
- SQUEEZE held 3 cycles around output 2, with DIN held by the bench: OUT/VALID frozen, no pixel lost or duplicated, sequence identical to the unstalled case.
- Two back-to-back frames, continuous DIN_VALID: 8 outputs, LAST_PIX on outputs 4 and 8, second frame values correct.
- RST asserted after 6 pixels, then a full frame: all outputs 0 for the reset cycle, then 4 outputs matching a clean frame.
- MODE toggled 0->1 at pixel 7: frame 1 stays max; frame 2 is average.
